// File: rtl/wb_deserializer.sv
// ---------------------------------------------------------------------------
// wb_deserializer
//
// Receives the serial data/ena stream from the companion serializer and
// rebuilds FRAME_BITS-wide frames (three 9-bit symbols, MSB first). Completed
// frames are queued in a small FIFO that software drains over a Wishbone
// slave register interface.
//
// Ports
//   CLK_I    clock, rising edge
//   RST_NI   asynchronous active-low reset
//   data_i   serial data bit, sampled when ena_i = 1
//   ena_i    bit-valid strobe, high for the whole frame
//   CYC_I    Wishbone cycle
//   STB_I    Wishbone strobe
//   WE_I     Wishbone write enable
//   ADR_I    address, only ADR_I[1:0] is decoded
//   DAT_I    write data
//   ACK_O    acknowledge (registered, one cycle)
//   ERR_O    error response instead of ACK_O (registered, one cycle)
//   DAT_O    read data, nonzero only while ACK_O = 1
//   frame_o  one-cycle pulse per completed frame (also for dropped frames)
//
// Register map (ADR_I[1:0])
//   0 RXDATA  read : {zero pad, head frame}, pops on the ACK edge; empty -> ERR
//   1 STATUS  read : {24'b0, level[3:0], FULL, EMPTY, OVF_ERR, FRM_ERR}
//   2 CTRL    write: bit0 clear FRM_ERR, bit1 clear OVF_ERR, bit2 flush FIFO
//                    read returns 0
//   3         any access -> ERR
//   Writes to 0 or 1 -> ERR
// ---------------------------------------------------------------------------
module wb_deserializer #(
    parameter int FRAME_BITS = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        data_i,
    input  logic        ena_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        frame_o
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // ------------------------------------------------------------------
    // Receiver: shift register plus bit counter
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_frame;

    logic                  w_last;
    logic                  w_frm_set;
    logic [FRAME_BITS-1:0] w_frame_data;

    assign w_last       = ena_i && (r_cnt == CW'(FRAME_BITS - 1));
    // Frame value including the bit being sampled this cycle.
    assign w_frame_data = {r_shift[FRAME_BITS-2:0], data_i};
    // Strobe dropped in the middle of a frame.
    assign w_frm_set    = !ena_i && (r_cnt != '0);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_last;
            if (ena_i) begin
                r_shift <= w_frame_data;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            end else begin
                // Partial frame bits left in r_shift are harmless: a new
                // frame overwrites every bit before it completes.
                r_cnt <= '0;
            end
        end
    end

    assign frame_o = r_frame;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_ovf_set;
    logic [AW-1:0]         w_waddr;
    logic [31:0]           w_level32;

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    // A same-cycle pop or flush frees space, so the new frame is kept.
    assign w_push    = w_last && (!w_full || w_pop || w_flush);
    assign w_ovf_set = w_last && !w_push;
    // A flush restarts the FIFO at slot 0, so a coincident frame lands there.
    assign w_waddr   = w_flush ? '0 : r_wr_ptr;
    assign w_level32 = 32'(r_level);

    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem[w_waddr] <= w_frame_data;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? AW'(1) : '0;
            r_level  <= w_push ? LW'(1) : '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set in the same cycle as a clear wins.
    // ------------------------------------------------------------------
    logic r_frm_err;
    logic r_ovf_err;
    logic w_clr_frm;
    logic w_clr_ovf;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_frm_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_frm_set) begin
                r_frm_err <= 1'b1;
            end else if (w_clr_frm) begin
                r_frm_err <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone slave
    //
    // Handshake: a request is CYC_I & STB_I sampled high while no response
    // is being presented. Exactly one of ACK_O/ERR_O answers it in the next
    // cycle, for one cycle only; DAT_O is valid only with ACK_O and is zero
    // otherwise. Register side effects (pop, CTRL) happen on that same edge.
    // Because the request term is masked by the response, a master holding
    // STB_I high is answered every other cycle.
    // ------------------------------------------------------------------
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_req;
    logic [1:0]  w_adr;
    logic        w_ack_d;
    logic        w_err_d;
    logic [31:0] w_dat_d;
    logic [31:0] w_status;

    assign w_req    = CYC_I & STB_I & ~r_ack & ~r_err;
    assign w_adr    = ADR_I[1:0];
    assign w_status = {24'b0, w_level32[3:0], w_full, w_empty, r_ovf_err, r_frm_err};

    always_comb begin
        w_ack_d   = 1'b0;
        w_err_d   = 1'b0;
        w_dat_d   = '0;
        w_pop     = 1'b0;
        w_clr_frm = 1'b0;
        w_clr_ovf = 1'b0;
        w_flush   = 1'b0;
        if (w_req) begin
            case (w_adr)
                2'd0: begin
                    if (WE_I || w_empty) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_ack_d = 1'b1;
                        w_dat_d = 32'(r_mem[r_rd_ptr]);
                        w_pop   = 1'b1;
                    end
                end
                2'd1: begin
                    if (WE_I) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_ack_d = 1'b1;
                        w_dat_d = w_status;
                    end
                end
                2'd2: begin
                    w_ack_d = 1'b1;
                    if (WE_I) begin
                        w_clr_frm = DAT_I[0];
                        w_clr_ovf = DAT_I[1];
                        w_flush   = DAT_I[2];
                    end
                end
                default: begin
                    w_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_ack_d;
            r_err <= w_err_d;
            r_dat <= w_dat_d;
        end
    end

    assign ACK_O = r_ack;
    assign ERR_O = r_err;
    assign DAT_O = r_dat;

    // Address and data bits outside the decoded fields are ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{ADR_I[31:2], DAT_I[31:3]};

endmodule
